// File: rtl/regfile_np_if.sv
// Bus bundle between the control unit (master) and the register file (slave).
// Carries the write port, both read ports and the clear-sequencer handshake.
interface regfile_np_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 2
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_W-1:0]     rd1_addr;
    logic [DATA_WIDTH-1:0] rd1_data;
    logic [ADDR_W-1:0]     rd2_addr;
    logic [DATA_WIDTH-1:0] rd2_data;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  clr_done;
    logic                  wr_drop;

    modport master (
        output wr_en, wr_addr, wr_data, rd1_addr, rd2_addr, clr_req,
        input  rd1_data, rd2_data, clr_busy, clr_done, wr_drop
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd1_addr, rd2_addr, clr_req,
        output rd1_data, rd2_data, clr_busy, clr_done, wr_drop
    );
endinterface

// File: rtl/regfile_np.sv
// Register file: two combinational read ports, one negedge write port, clear sequencer.
// Optional REGFILE_BYPASS_EN forwards an accepted write to matching read ports in the same cycle.
module regfile_np #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter bit ZERO_REG   = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    regfile_np_if.slave bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_e;

    state_e                state_q;
    logic [ADDR_W-1:0]     cnt_q;
    logic                  clr_busy_q;
    logic                  clr_done_q;
    logic                  wr_drop_q;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  wr_to_zero;
    logic                  wr_accept;
    logic [ADDR_W-1:0]     rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];

    // A write to the hard-wired zero register is swallowed silently, not reported as a drop.
    assign wr_to_zero = ZERO_REG && (bus.wr_addr == '0);
    assign wr_accept  = (state_q == ST_IDLE) && bus.wr_en && !wr_to_zero;

    // Storage next-state: at most one write and one clear target per edge; the
    // two never coincide because writes are only accepted in IDLE.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_accept) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
        if (state_q == ST_CLEAR) begin
            regs_d[cnt_q] = '0;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is small and must read zero straight out of reset, so it is reset like any other flop rather than left as an uninitialised RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values regardless of statement order.
            regs_q <= regs_d;
        end
    end

    // Clear sequencer: IDLE -> CLEAR (NUM_REGS cycles, one register per edge) -> DONE (one cycle) -> IDLE.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            wr_drop_q  <= bus.wr_en && (state_q != ST_IDLE);
            clr_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state_q    <= ST_CLEAR;
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q    <= ST_DONE;
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= '0;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr[0] = bus.rd1_addr;
    assign rd_addr[1] = bus.rd2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_accept && (rd_addr[p] == bus.wr_addr)) begin
                rd_data[p] = bus.wr_data;
            end
`endif
            if (ZERO_REG && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end
        end
    end

    assign bus.rd1_data = rd_data[0];
    assign bus.rd2_data = rd_data[1];
    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;
    assign bus.wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_np.sv
// Scoreboard bench for regfile_np: one instance with ZERO_REG=0, one with ZERO_REG=1.
// Stimulus pushes expectations; a monitor pops and compares them at each posedge.
module tb_regfile_np;

    localparam int DW = 8;
    localparam int AW = 2;

    localparam int A_RD1  = 0;
    localparam int A_RD2  = 1;
    localparam int A_BUSY = 2;
    localparam int A_DONE = 3;
    localparam int A_DROP = 4;
    localparam int B_RD1  = 5;
    localparam int B_DROP = 6;

    logic clk;
    logic rst_n;

    regfile_np_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) ia ();
    regfile_np_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) ib ();

    regfile_np #(.DATA_WIDTH(DW), .NUM_REGS(4), .ZERO_REG(1'b0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.slave)
    );

    regfile_np #(.DATA_WIDTH(DW), .NUM_REGS(4), .ZERO_REG(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    string        q_name [$];
    int           q_sel  [$];
    logic [DW-1:0] q_val [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic expect_v(input string name, input int sel, input logic [DW-1:0] val);
        q_name.push_back(name);
        q_sel.push_back(sel);
        q_val.push_back(val);
    endtask

    function automatic logic [DW-1:0] dut_val(input int sel);
        case (sel)
            A_RD1:   return ia.rd1_data;
            A_RD2:   return ia.rd2_data;
            A_BUSY:  return DW'(ia.clr_busy);
            A_DONE:  return DW'(ia.clr_done);
            A_DROP:  return DW'(ia.wr_drop);
            B_RD1:   return ib.rd1_data;
            B_DROP:  return DW'(ib.wr_drop);
            default: return 'x;
        endcase
    endfunction

    // Monitor: outputs are sampled on posedge, half a cycle away from the negedge update.
    always @(posedge clk) begin
        while (q_sel.size() != 0) begin
            string         n;
            int            s;
            logic [DW-1:0] v;
            n = q_name.pop_front();
            s = q_sel.pop_front();
            v = q_val.pop_front();
            check(n, 32'(dut_val(s)), 32'(v));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ia.wr_en = 1'b0; ia.wr_addr = '0; ia.wr_data = '0;
        ia.rd1_addr = '0; ia.rd2_addr = '0; ia.clr_req = 1'b0;
        ib.wr_en = 1'b0; ib.wr_addr = '0; ib.wr_data = '0;
        ib.rd1_addr = '0; ib.rd2_addr = '0; ib.clr_req = 1'b0;
    endtask

    task automatic a_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ia.wr_en   = 1'b1;
        ia.wr_addr = addr;
        ia.wr_data = data;
    endtask

    task automatic a_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        ia.rd1_addr = a1;
        ia.rd2_addr = a2;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        cyc();
        cyc();
        rst_n = 1'b1;

        // Out of reset
        a_read(2'd1, 2'd3);
        expect_v("rst_rd1", A_RD1, 8'h00);
        expect_v("rst_rd2", A_RD2, 8'h00);
        expect_v("rst_busy", A_BUSY, 8'h0);
        expect_v("rst_done", A_DONE, 8'h0);
        expect_v("rst_drop", A_DROP, 8'h0);
        cyc();

        // Write / read
        a_write(2'd2, 8'hA5);
        a_read(2'd2, 2'd0);
`ifdef REGFILE_BYPASS_EN
        expect_v("a_pre_edge_rd1", A_RD1, 8'hA5);
`else
        expect_v("a_pre_edge_rd1", A_RD1, 8'h00);
`endif
        cyc();
        a_write(2'd3, 8'h3C);
        a_read(2'd2, 2'd3);
        expect_v("wr_rd1_reg2", A_RD1, 8'hA5);
`ifdef REGFILE_BYPASS_EN
        expect_v("wr_rd2_reg3_pre", A_RD2, 8'h3C);
`else
        expect_v("wr_rd2_reg3_pre", A_RD2, 8'h00);
`endif
        cyc();
        ia.wr_en = 1'b0;
        expect_v("wr_rd1_reg2_b", A_RD1, 8'hA5);
        expect_v("wr_rd2_reg3", A_RD2, 8'h3C);
        cyc();
        a_read(2'd2, 2'd2);
        expect_v("both_rd1_reg2", A_RD1, 8'hA5);
        expect_v("both_rd2_reg2", A_RD2, 8'hA5);
        cyc();

        // Fill, then clear; the last fill write coincides with clr_req
        for (int i = 0; i < 3; i++) begin
            a_write(AW'(i), DW'(8'h11 * (i + 1)));
            cyc();
        end
        a_write(2'd3, 8'h44);
        ia.clr_req = 1'b1;
        expect_v("pre_clr_busy", A_BUSY, 8'h0);
        cyc();
        ia.wr_en = 1'b0;
        ia.clr_req = 1'b0;
        a_read(2'd0, 2'd3);
        expect_v("clr1_busy", A_BUSY, 8'h1);
        expect_v("clr1_done", A_DONE, 8'h0);
        expect_v("clr1_drop", A_DROP, 8'h0);
        expect_v("clr1_rd_reg0", A_RD1, 8'h11);
        expect_v("clr1_rd_reg3", A_RD2, 8'h44);
        cyc();
        a_read(2'd0, 2'd1);
        a_write(2'd1, 8'hFF);
        expect_v("clr2_busy", A_BUSY, 8'h1);
        expect_v("clr2_rd_reg0", A_RD1, 8'h00);
        expect_v("clr2_rd_reg1", A_RD2, 8'h22);
        cyc();
        ia.wr_en = 1'b0;
        a_read(2'd1, 2'd2);
        expect_v("clr3_busy", A_BUSY, 8'h1);
        expect_v("clr3_drop", A_DROP, 8'h1);
        expect_v("clr3_rd_reg1", A_RD1, 8'h00);
        expect_v("clr3_rd_reg2", A_RD2, 8'h33);
        cyc();
        ia.clr_req = 1'b1;
        a_read(2'd2, 2'd3);
        expect_v("clr4_busy", A_BUSY, 8'h1);
        expect_v("clr4_drop", A_DROP, 8'h0);
        expect_v("clr4_done", A_DONE, 8'h0);
        expect_v("clr4_rd_reg2", A_RD1, 8'h00);
        expect_v("clr4_rd_reg3", A_RD2, 8'h44);
        cyc();
        expect_v("done_busy", A_BUSY, 8'h0);
        expect_v("done_pulse", A_DONE, 8'h1);
        expect_v("done_rd_reg3", A_RD2, 8'h00);
        cyc();
        ia.clr_req = 1'b0;
        a_read(2'd0, 2'd1);
        expect_v("post_busy", A_BUSY, 8'h0);
        expect_v("post_done", A_DONE, 8'h0);
        expect_v("post_rd_reg0", A_RD1, 8'h00);
        expect_v("post_rd_reg1", A_RD2, 8'h00);
        cyc();
        a_read(2'd2, 2'd3);
        expect_v("post2_busy", A_BUSY, 8'h0);
        expect_v("post2_rd_reg2", A_RD1, 8'h00);
        expect_v("post2_rd_reg3", A_RD2, 8'h00);
        cyc();

        // Reset in the middle of a clear
        a_write(2'd3, 8'h77);
        cyc();
        a_write(2'd2, 8'h66);
        ia.clr_req = 1'b1;
        cyc();
        ia.wr_en = 1'b0;
        ia.clr_req = 1'b0;
        a_read(2'd2, 2'd3);
        expect_v("mc_busy", A_BUSY, 8'h1);
        expect_v("mc_rd_reg2", A_RD1, 8'h66);
        expect_v("mc_rd_reg3", A_RD2, 8'h77);
        cyc();
        cyc();
        rst_n = 1'b0;
        expect_v("arst_rd_reg2", A_RD1, 8'h00);
        expect_v("arst_rd_reg3", A_RD2, 8'h00);
        expect_v("arst_busy", A_BUSY, 8'h0);
        expect_v("arst_done", A_DONE, 8'h0);
        expect_v("arst_drop", A_DROP, 8'h0);
        cyc();
        rst_n = 1'b1;
        expect_v("rel_busy", A_BUSY, 8'h0);
        expect_v("rel_done", A_DONE, 8'h0);
        cyc();
        a_write(2'd0, 8'h5A);
        a_read(2'd0, 2'd2);
        expect_v("rel2_done", A_DONE, 8'h0);
        cyc();
        ia.wr_en = 1'b0;
        expect_v("rel_wr_reg0", A_RD1, 8'h5A);
        expect_v("rel_rd_reg2", A_RD2, 8'h00);
        expect_v("rel3_busy", A_BUSY, 8'h0);
        cyc();

        // Hard-wired zero register on the second instance
        ib.wr_en = 1'b1;
        ib.wr_addr = 2'd0;
        ib.wr_data = 8'h77;
        ib.rd1_addr = 2'd0;
        expect_v("z_rd0_pre", B_RD1, 8'h00);
        cyc();
        ib.wr_addr = 2'd1;
        ib.wr_data = 8'h12;
        expect_v("z_rd0_post", B_RD1, 8'h00);
        expect_v("z_no_drop", B_DROP, 8'h0);
        cyc();
        ib.wr_data = 8'h9C;
        ib.rd1_addr = 2'd1;
`ifdef REGFILE_BYPASS_EN
        expect_v("z_fwd_reg1", B_RD1, 8'h9C);
`else
        expect_v("z_fwd_reg1", B_RD1, 8'h12);
`endif
        cyc();
        ib.wr_en = 1'b0;
        expect_v("z_rd_reg1", B_RD1, 8'h9C);
        expect_v("z_drop2", B_DROP, 8'h0);
        cyc();

        cyc();
        cyc();
        check("scoreboard_drained", 32'(q_sel.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
